// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked (multi-cycle) wide adder:
// FSM state encoding, default geometry and the chunk-counter width.
package chunked_adder_pkg;

    // Default chunk width and chunk count; W = bw * nchunk.
    localparam int bw_default     = 4;
    localparam int nchunk_default = 4;

    // Width of a counter that indexes chunks 0 .. n-1 (at least one bit).
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int kw_default = counter_width(nchunk_default);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational bw-bit ripple-carry adder. Bit 1 is the LSB so that a
// chunk lifted straight out of a [W:1] operand lines up bit for bit.
module ripple_carry_adder #(
    parameter int bw = 4
) (
    input  logic [bw:1] a,
    input  logic [bw:1] b,
    input  logic        cin,
    output logic [bw:1] sum,
    output logic        cout
);

    logic c;

    // Ripple the carry from bit 1 up to bit bw.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        sum = '0;
        c   = cin;
        for (int i = 1; i <= bw; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle wide adder: adds two W-bit operands one bw-bit chunk per
// clock through a single ripple_carry_adder. The inter-chunk carry lives
// in a register, so the critical path is one chunk ripple regardless of W.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int bw     = bw_default,
    parameter int nchunk = nchunk_default
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [bw*nchunk:1]   A,
    input  logic [bw*nchunk:1]   B,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [bw*nchunk:1]   sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int w  = bw * nchunk;
    localparam int kw = counter_width(nchunk);
    localparam logic [kw-1:0] k_last = kw'(nchunk - 1);

    state_t          state_q, state_d;
    logic [w:1]      a_q, b_q, sum_q;
    logic            carry_q, cout_q, ovf_q;
    logic [kw-1:0]   k_q;

    logic            accept;
    logic            last_chunk;
    int              base;
    logic [bw:1]     a_chunk, b_chunk, add_sum;
    logic            add_cout;

    // A new start is taken whenever no addition is in flight.
    assign accept     = start && (state_q != RUN);
    assign last_chunk = (k_q == k_last);

    // Select chunk k of the latched operands; base is the chunk's lowest bit.
    always_comb begin
        base    = int'(k_q) * bw + 1;
        a_chunk = a_q[base +: bw];
        b_chunk = b_q[base +: bw];
    end

    ripple_carry_adder #(
        .bw(bw)
    ) u_rca (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_chunk) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, carry chain, chunk counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= cin;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == RUN) begin
            sum_q[base +: bw] <= add_sum;
            carry_q           <= add_cout;
            if (last_chunk) begin
                k_q    <= '0;
                cout_q <= add_cout;
                // Overflow is carry-out XOR carry into the MSB; the latter is
                // recovered from the MSB operand bits and the new sum bit.
                ovf_q  <= add_cout ^ (a_q[w] ^ b_q[w] ^ add_sum[bw]);
            end else begin
                k_q <= k_q + kw'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder (bw = 4, nchunk = 4, W = 16). Stimulus pushes
// the expected result into a queue; a monitor pops and compares on done.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:1] A, B;
    logic        cin;
    logic        busy, done, cout, ovf;
    logic [16:1] sum;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    chunked_adder #(
        .bw     (4),
        .nchunk (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum",  {16'd0, sum}, {16'd0, e.sum});
                check("cout", {31'd0, cout}, {31'd0, e.cout});
                check("ovf",  {31'd0, ovf}, {31'd0, e.ovf});
            end
        end
    end

    // Present operands with start for one edge; returns 1 ns after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input bit push);
        exp_t e;
        e.sum = es; e.cout = ec; e.ovf = eo;
        if (push) exp_q.push_back(e);
        A = a; B = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); cin = 1'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_low_in_run",  {31'd0, done}, 32'd0);
        check("sum_cleared",      {16'd0, sum},  32'd0);
    endtask

    // Count edges from the accept edge until done; expects exactly nchunk.
    task automatic wait_done(input int already);
        int n = already;
        while (done !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency_edges", n, 32'd4);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic add(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec, input logic eo);
        issue(a, b, c, es, ec, eo, 1'b1);
        wait_done(0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [16:0] full;
        logic [15:0] ra, rb;
        logic        rc, rovf;

        rst = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum",  {16'd0, sum},  32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        check("reset_ovf",  {31'd0, ovf},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors; each call after the first starts in the DONE cycle.
        add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Second start during RUN must be ignored.
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2);
        repeat (6) @(posedge clk);
        #1;
        check("idle_after_single_done", {31'd0, busy}, 32'd0);

        // Reset in the third RUN cycle discards the operation.
        issue(16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum",  {16'd0, sum},  32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_ovf",  {31'd0, ovf},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_stays_idle", {31'd0, busy}, 32'd0);

        add(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        // Back-to-back: issued in the DONE cycle of the previous add.
        add(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Random tuples against a 17-bit reference sum.
        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
            add(ra, rb, rc, full[15:0], full[16], rovf);
        end

        repeat (4) @(posedge clk);
        #1;
        check("no_pending_results", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
